// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter and sequencer that shares one uart_tx2 transmitter
//   between N_REQ byte requesters. It accepts one byte from the winning
//   requester, pulses TX_DV/TX_BYTE into the transmitter, and then follows
//   the DONE handshake until the frame completes. A watchdog recovers if the
//   transmitter never drops DONE after a TX_DV pulse.
//
// Parameters
//   N_REQ   : number of requesters (2..8)
//   TIMEOUT : cycles to wait for TX_DONE to fall after TX_DV before ERR
//
// Ports
//   CLK, RST_N  : clock (posedge) and asynchronous active-low reset
//   REQ_VALID   : per-requester byte valid
//   REQ_BYTE    : per-requester byte, requester i on [8i+7:8i]
//   REQ_READY   : per-requester accept (transfer on VALID & READY)
//   TX_DV       : one-cycle data-valid pulse to uart_tx2
//   TX_BYTE     : byte to uart_tx2, held outside the issue cycle
//   TX_DONE     : uart_tx2 DONE (1 = idle, 0 = frame in progress)
//   GNT_IDX     : index of the last granted requester
//   BUSY        : high in any state other than IDLE
//   ERR         : one-cycle pulse on watchdog timeout
//
// Optional build macro UART_TX_ARB_LOCK_EN
//   Adds REQ_LAST (input, per requester) and LOCKED (output). A transfer with
//   REQ_LAST[winner]=0 locks the grant to that requester until a transfer
//   with REQ_LAST=1 or a watchdog timeout.

module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [N_REQ-1:0]         REQ_VALID,
  input  logic [8*N_REQ-1:0]       REQ_BYTE,
  output logic [N_REQ-1:0]         REQ_READY,
  output logic                     TX_DV,
  output logic [7:0]               TX_BYTE,
  input  logic                     TX_DONE,
  output logic [$clog2(N_REQ)-1:0] GNT_IDX,
  output logic                     BUSY,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [N_REQ-1:0]         REQ_LAST,
  output logic                     LOCKED,
`endif
  output logic                     ERR
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] win;
  logic          win_vld;
  logic [IW:0]   rr_sum;
  logic [7:0]    win_byte;
  logic          xfer;
  logic          wd_hit;

`ifdef UART_TX_ARB_LOCK_EN
  logic lock_q;
  assign LOCKED = lock_q;
`endif

  // Rotating-priority search starting just after the last grant. Walking k
  // from farthest to nearest lets the nearest valid requester win without a
  // priority encoder. The sum is one bit wider than IW so the modulo wrap is
  // exact for non-power-of-2 N_REQ.
  always_comb begin
    win     = GNT_IDX;
    win_vld = 1'b0;
    rr_sum  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      rr_sum = {1'b0, GNT_IDX} + (IW+1)'(k);
      if (rr_sum >= (IW+1)'(N_REQ)) rr_sum = rr_sum - (IW+1)'(N_REQ);
      if (REQ_VALID[IW'(rr_sum)]) begin
        win     = IW'(rr_sum);
        win_vld = 1'b1;
      end
    end
`ifdef UART_TX_ARB_LOCK_EN
    // A locked grant only ever re-selects the same requester.
    if (lock_q) begin
      win     = GNT_IDX;
      win_vld = REQ_VALID[GNT_IDX];
    end
`endif
  end

  assign win_byte = REQ_BYTE[{win, 3'b000} +: 8];

  // READY is purely a function of state, TX_DONE and the current VALIDs.
  always_comb begin
    REQ_READY = '0;
    if (state == S_IDLE && TX_DONE && win_vld)
      REQ_READY = {{(N_REQ-1){1'b0}}, 1'b1} << win;
  end

  assign xfer   = |REQ_READY;
  assign TX_DV  = (state == S_ISSUE);
  assign BUSY   = (state != S_IDLE);
  // The counter holds cycles spent in WAIT_BUSY minus one, so the timeout
  // fires exactly TIMEOUT cycles after the TX_DV pulse.
  assign wd_hit = (state == S_WAIT_BUSY) && TX_DONE && (cnt == CW'(TIMEOUT-1));
  assign ERR    = wd_hit;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      TX_BYTE <= '0;
      GNT_IDX <= IW'(N_REQ-1);
      cnt     <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (xfer) begin
            TX_BYTE <= win_byte;
            GNT_IDX <= win;
            state   <= S_ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q  <= ~REQ_LAST[win];
`endif
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!TX_DONE) begin
            state <= S_WAIT_DONE;
          end else if (wd_hit) begin
            // Transmitter never acknowledged: drop the byte and recover.
            state  <= S_IDLE;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (TX_DONE) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (N_REQ=4, TIMEOUT=8). A small
// uart_tx2 stand-in drives TX_DONE; a transaction-level model predicts
// grants, bytes, pulses and watchdog timing from the arbitration rules.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic           CLK = 1'b0;
  logic           RST_N;
  logic [N-1:0]   REQ_VALID;
  logic [8*N-1:0] REQ_BYTE;
  logic [N-1:0]   REQ_READY;
  logic           TX_DV;
  logic [7:0]     TX_BYTE;
  logic           TX_DONE;
  logic [1:0]     GNT_IDX;
  logic           BUSY;
  logic           ERR;
`ifdef UART_TX_ARB_LOCK_EN
  logic [N-1:0]   REQ_LAST = '1;
  logic           LOCKED;
`endif

  always #5 CLK = ~CLK;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_BYTE(REQ_BYTE), .REQ_READY(REQ_READY),
    .TX_DV(TX_DV), .TX_BYTE(TX_BYTE), .TX_DONE(TX_DONE),
    .GNT_IDX(GNT_IDX), .BUSY(BUSY),
`ifdef UART_TX_ARB_LOCK_EN
    .REQ_LAST(REQ_LAST), .LOCKED(LOCKED),
`endif
    .ERR(ERR)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // requester stimulus
  logic [N-1:0] pend;
  logic [7:0]   pbyte [N];
  // transmitter stand-in
  bit stub, hold_low, dv_prev;
  int frame_cnt;
  // reference model
  int         m_last, m_since;
  bit         m_busy, m_dv_due, m_low;
  logic [7:0] m_byte;
  logic [N-1:0] m_acc;
  int cyc, dv_cyc, err_cnt;

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    logic [N-1:0] s;
    for (int k = 1; k <= N; k++) begin
      s = v >> ((last + k) % N);
      if (s[0]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = N-1; m_busy = 0; m_dv_due = 0; m_low = 0; m_since = 0;
    m_byte = 8'h00; m_acc = '0;
  endtask

  task automatic model_check();
    int w;
    logic [N-1:0] exp_ready;
    bit exp_err;
    w = -1; exp_ready = '0;
    if (!m_busy && TX_DONE && (|REQ_VALID)) begin
      w = rr_pick(m_last, REQ_VALID);
      exp_ready = N'(1) << w;
    end
    exp_err = m_busy && !m_dv_due && !m_low && TX_DONE && (m_since == TO);
    chk("ready", REQ_READY, exp_ready);
    chk("dv",    TX_DV,     m_dv_due);
    chk("busy",  BUSY,      m_busy);
    chk("err",   ERR,       exp_err);
    chk("gnt",   GNT_IDX,   m_last);
    chk("byte",  TX_BYTE,   m_byte);
    if (TX_DV) dv_cyc = cyc;
    if (ERR) begin
      err_cnt++;
      chk("wd_lat", cyc - dv_cyc, TO);
    end
    m_acc = exp_ready;
    if (w >= 0) begin
      m_last = w; m_byte = pbyte[w]; m_busy = 1; m_dv_due = 1; m_low = 0;
    end else if (m_dv_due) begin
      m_dv_due = 0; m_since = 1;
    end else if (m_busy && !m_low) begin
      if (!TX_DONE)          m_low = 1;
      else if (m_since == TO) m_busy = 0;
      else                   m_since++;
    end else if (m_busy && m_low && TX_DONE) begin
      m_busy = 0;
    end
  endtask

  task automatic step();
    @(posedge CLK); #1; cyc++;
    if (dv_prev && !stub) frame_cnt = $urandom_range(2, 6);
    if (frame_cnt > 0) begin TX_DONE = 1'b0; frame_cnt--; end
    else TX_DONE = !hold_low;
    REQ_VALID = pend;
    for (int i = 0; i < N; i++) REQ_BYTE[8*i +: 8] = pbyte[i];
    @(negedge CLK);
    model_check();
    dv_prev = TX_DV;
  endtask

  task automatic step_acc();
    step();
    pend = pend & ~m_acc;
  endtask

  task automatic run_until_idle(input string tag, input int max);
    int n = 0;
    while ((m_busy || frame_cnt > 0 || !TX_DONE) && n < max) begin
      step_acc(); n++;
    end
    chk({tag, "_to"}, n < max, 1);
  endtask

  task automatic do_reset(input string tag);
    #2 RST_N = 1'b0;
    #1;
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_dv"},   TX_DV, 0);
    chk({tag, "_gnt"},  GNT_IDX, N-1);
    chk({tag, "_err"},  ERR, 0);
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    model_reset();
    dv_prev = 0;
  endtask

  initial begin
    int n, got_n;
    RST_N = 1'b0; pend = '0; stub = 0; hold_low = 0; frame_cnt = 0; dv_prev = 0;
    for (int i = 0; i < N; i++) pbyte[i] = 8'h00;
    TX_DONE = 1'b1; REQ_VALID = '0; REQ_BYTE = '0;
    cyc = 0; dv_cyc = 0; err_cnt = 0;
    model_reset();
    #12;
    chk("rst_busy",  BUSY, 0);
    chk("rst_dv",    TX_DV, 0);
    chk("rst_gnt",   GNT_IDX, N-1);
    chk("rst_err",   ERR, 0);
    chk("rst_ready", REQ_READY, 0);
    chk("rst_byte",  TX_BYTE, 0);
    @(negedge CLK); RST_N = 1'b1;

    // single byte from requester 2
    pend = 4'b0100; pbyte[2] = 8'hA5;
    step_acc();
    chk("single_rdy", REQ_READY, 4'b0100);
    step_acc();
    chk("single_dv", TX_DV, 1);
    chk("single_byte", TX_BYTE, 8'hA5);
    chk("single_gnt", GNT_IDX, 2);
    run_until_idle("single", 40);

    // back-pressure: DONE low in IDLE blocks the grant
    hold_low = 1; pend = 4'b0001; pbyte[0] = 8'h3C;
    repeat (5) begin
      step_acc();
      chk("bp_ready", REQ_READY, 0);
    end
    hold_low = 0;
    step_acc();
    chk("bp_release", REQ_READY, 4'b0001);
    run_until_idle("bp", 40);

    // watchdog: transmitter ignores TX_DV
    stub = 1; err_cnt = 0; pend = 4'b0010; pbyte[1] = 8'h5A;
    repeat (14) step_acc();
    chk("wd_seen", err_cnt, 1);
    stub = 0;
    pend = 4'b0100; pbyte[2] = 8'h77;
    step_acc();
    chk("wd_after", REQ_READY, 4'b0100);
    run_until_idle("wd", 40);

    // round-robin with all requesters valid, fresh priority after reset
    do_reset("rst_idle");
    pend = 4'b1111;
    for (int i = 0; i < N; i++) pbyte[i] = 8'h10 + 8'(i);
    n = 0; got_n = 0;
    while (got_n < 5 && n < 200) begin
      step();
      if (TX_DV) begin
        chk($sformatf("rr%0d", got_n), TX_BYTE, 8'h10 + (got_n % N));
        got_n++;
      end
      n++;
    end
    chk("rr_to", n < 200, 1);
    pend = '0;
    run_until_idle("rr", 40);

    // reset in the middle of a frame
    pend = 4'b0001; pbyte[0] = 8'hC3;
    n = 0;
    while (!m_low && n < 40) begin step_acc(); n++; end
    chk("mid_to", n < 40, 1);
    pend = 4'b1001; pbyte[0] = 8'hC4; pbyte[3] = 8'hE1;
    do_reset("rst_mid");
    n = 0;
    while (!TX_DV && n < 40) begin step_acc(); n++; end
    chk("mid_dv_to", n < 40, 1);
    chk("post_rst_win", GNT_IDX, 0);
    pend = '0;
    run_until_idle("mid", 40);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1; pbyte[i] = 8'($urandom);
        end else if (pend[i] && $urandom_range(0, 31) == 0) begin
          pend[i] = 1'b0;
        end
      end
      if (!m_busy && frame_cnt == 0) stub = ($urandom_range(0, 9) == 0);
      hold_low = ($urandom_range(0, 5) == 0);
      step_acc();
    end
    stub = 0; hold_low = 0; pend = '0;
    run_until_idle("rand", 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
